// File: rtl/acl2_pkg.sv
// Shared types and constants for the ADXL362 burst demultiplexer.
package acl2_pkg;

  localparam int unsigned NUM_CH   = 6;
  localparam int unsigned LAST_IDX = 5;
  localparam int unsigned IDX_W    = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/acl2_watchdog.sv
// Loadable down-counter that flags an idle gap inside a frame.
// load_i restarts the count at CYCLES-1. While run_i stays high, expire_c_o
// fires in the cycle that ends exactly CYCLES idle cycles after the load.
module acl2_watchdog #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic expire_c_o
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Reload on every accepted byte or start, otherwise count down while collecting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(CYCLES - 1);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expire_c_o = run_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/acl2_burst_demux.sv
// Steers the six bytes of an ADXL362 burst read (X/Y/Z, low byte first) into
// six output registers. The outputs update together when the sixth byte
// arrives, so consumers never see a mixed frame.
// Compile-time option: ACL2_DEMUX_TIMEOUT_EN adds an inter-byte idle timeout
// that abandons a stalled partial frame.
module acl2_burst_demux
  import acl2_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic [WIDTH-1:0] d5,
  output logic [2:0]       sel,
  output logic             busy,
  output logic             frame_valid,
  output logic             abort,
  output logic             stray
);

  state_e           state_q;
  idx_t             sel_q;
  logic             busy_q;
  logic             frame_valid_q;
  logic             abort_q;
  logic             stray_q;
  logic [WIDTH-1:0] stg_q [NUM_CH];
  logic [WIDTH-1:0] out_q [NUM_CH];
  logic             expire_c;

`ifdef ACL2_DEMUX_TIMEOUT_EN
  logic wd_load_c;

  // Restart the idle count on start and on every byte accepted mid-frame
  assign wd_load_c = start || (din_valid && (state_q == COLLECT));

  acl2_watchdog #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wd_load_c),
    .run_i      (state_q == COLLECT),
    .expire_c_o (expire_c)
  );
`else
  // Without the timeout a stalled frame waits for start or reset
  assign expire_c = 1'b0;
`endif

  // Frame collection state machine with registered outputs and pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      abort_q       <= 1'b0;
      stray_q       <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        stg_q[k] <= '0;
        out_q[k] <= '0;
      end
    end else begin
      frame_valid_q <= 1'b0;
      abort_q       <= 1'b0;
      stray_q       <= 1'b0;

      if (start) begin
        // start always wins; a coincident byte belongs to no frame
        stray_q <= din_valid;
        abort_q <= (state_q == COLLECT);
        state_q <= COLLECT;
        busy_q  <= 1'b1;
        sel_q   <= '0;
        for (int k = 0; k < NUM_CH; k++) begin
          stg_q[k] <= '0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (din_valid) begin
              stray_q <= 1'b1;
            end
          end
          COLLECT: begin
            if (din_valid) begin
              if (sel_q == idx_t'(LAST_IDX)) begin
                for (int k = 0; k < NUM_CH - 1; k++) begin
                  out_q[k] <= stg_q[k];
                end
                out_q[LAST_IDX] <= din;
                frame_valid_q   <= 1'b1;
                sel_q           <= '0;
                state_q         <= IDLE;
                busy_q          <= 1'b0;
              end else begin
                for (int k = 0; k < NUM_CH - 1; k++) begin
                  if (sel_q == idx_t'(k)) begin
                    stg_q[k] <= din;
                  end
                end
                sel_q <= sel_q + idx_t'(1);
              end
            end else if (expire_c) begin
              abort_q <= 1'b1;
              sel_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            sel_q   <= '0;
          end
        endcase
      end
    end
  end

  assign d0          = out_q[0];
  assign d1          = out_q[1];
  assign d2          = out_q[2];
  assign d3          = out_q[3];
  assign d4          = out_q[4];
  assign d5          = out_q[5];
  assign sel         = sel_q;
  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;
  assign abort       = abort_q;
  assign stray       = stray_q;

endmodule

// File: tb/tb_acl2_burst_demux.sv
// Directed bench for acl2_burst_demux; expected values are hand-derived.
// Builds with or without ACL2_DEMUX_TIMEOUT_EN.
module tb_acl2_burst_demux;

  localparam int unsigned W  = 8;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] din;
  logic         din_valid;
  logic [W-1:0] d0, d1, d2, d3, d4, d5;
  logic [2:0]   sel;
  logic         busy, frame_valid, abort, stray;

  int errors = 0;
  int checks = 0;

  acl2_burst_demux #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .din         (din),
    .din_valid   (din_valid),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .d4          (d4),
    .d5          (d5),
    .sel         (sel),
    .busy        (busy),
    .frame_valid (frame_valid),
    .abort       (abort),
    .stray       (stray)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are read 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3,
                           input logic [W-1:0] e4, input logic [W-1:0] e5);
    chk({tag, "_d0"}, 32'(d0), 32'(e0));
    chk({tag, "_d1"}, 32'(d1), 32'(e1));
    chk({tag, "_d2"}, 32'(d2), 32'(e2));
    chk({tag, "_d3"}, 32'(d3), 32'(e3));
    chk({tag, "_d4"}, 32'(d4), 32'(e4));
    chk({tag, "_d5"}, 32'(d5), 32'(e5));
  endtask

  // Drive one byte and check the cycle after it is sampled
  task automatic send_byte(input string tag, input logic [W-1:0] b, input int idx);
    din       = b;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    chk({tag, "_abort"}, 32'(abort), 32'd0);
    chk({tag, "_stray"}, 32'(stray), 32'd0);
    if (idx < 5) begin
      chk({tag, "_fv"},   32'(frame_valid), 32'd0);
      chk({tag, "_sel"},  32'(sel),         32'(idx + 1));
      chk({tag, "_busy"}, 32'(busy),        32'd1);
    end else begin
      chk({tag, "_fv_last"},   32'(frame_valid), 32'd1);
      chk({tag, "_sel_last"},  32'(sel),         32'd0);
      chk({tag, "_busy_last"}, 32'(busy),        32'd0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = '0; din_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    chk("rst_sel",   32'(sel),         32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_fv",    32'(frame_valid), 32'd0);
    chk("rst_abort", 32'(abort),       32'd0);
    chk("rst_stray", 32'(stray),       32'd0);
    chk_frame("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Basic frame 0x11..0x66
    pulse_start();
    chk("f1_start_busy",  32'(busy),  32'd1);
    chk("f1_start_sel",   32'(sel),   32'd0);
    chk("f1_start_abort", 32'(abort), 32'd0);
    send_byte("f1_b0", 8'h11, 0);
    send_byte("f1_b1", 8'h22, 1);
    send_byte("f1_b2", 8'h33, 2);
    send_byte("f1_b3", 8'h44, 3);
    send_byte("f1_b4", 8'h55, 4);
    chk_frame("f1_pre", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_byte("f1_b5", 8'h66, 5);
    chk_frame("f1", 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    cyc();
    chk("f1_fv_one_cycle", 32'(frame_valid), 32'd0);

    // Partial frame aborted by a second start
    pulse_start();
    send_byte("ab_b0", 8'h91, 0);
    send_byte("ab_b1", 8'h92, 1);
    send_byte("ab_b2", 8'h93, 2);
    pulse_start();
    chk("ab_abort", 32'(abort),       32'd1);
    chk("ab_sel",   32'(sel),         32'd0);
    chk("ab_busy",  32'(busy),        32'd1);
    chk("ab_fv",    32'(frame_valid), 32'd0);
    chk_frame("ab_hold", 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    send_byte("ab2_b0", 8'hA0, 0);
    send_byte("ab2_b1", 8'hA1, 1);
    send_byte("ab2_b2", 8'hA2, 2);
    send_byte("ab2_b3", 8'hA3, 3);
    send_byte("ab2_b4", 8'hA4, 4);
    send_byte("ab2_b5", 8'hA5, 5);
    chk_frame("ab2", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5);
    cyc();

    // Stray byte in IDLE
    din = 8'h7F; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    chk("st_stray", 32'(stray), 32'd1);
    chk("st_sel",   32'(sel),   32'd0);
    chk("st_busy",  32'(busy),  32'd0);
    chk("st_fv",    32'(frame_valid), 32'd0);
    chk_frame("st", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5);
    cyc();
    chk("st_stray_one_cycle", 32'(stray), 32'd0);

    // start + din_valid together: in IDLE, then in COLLECT
    start = 1'b1; din = 8'hEE; din_valid = 1'b1;
    cyc();
    chk("sv_idle_stray", 32'(stray), 32'd1);
    chk("sv_idle_abort", 32'(abort), 32'd0);
    chk("sv_idle_busy",  32'(busy),  32'd1);
    chk("sv_idle_sel",   32'(sel),   32'd0);
    cyc();
    chk("sv_coll_stray", 32'(stray), 32'd1);
    chk("sv_coll_abort", 32'(abort), 32'd1);
    chk("sv_coll_sel",   32'(sel),   32'd0);
    start = 1'b0; din_valid = 1'b0;

    // Stall after two bytes
    send_byte("to_b0", 8'hB0, 0);
    send_byte("to_b1", 8'hB1, 1);
`ifdef ACL2_DEMUX_TIMEOUT_EN
    for (int i = 1; i <= int'(TO); i++) begin
      cyc();
      if (i < int'(TO)) begin
        if (abort !== 1'b0 || busy !== 1'b1) chk("to_early", 32'({abort, busy}), 32'b01);
      end
    end
    chk("to_abort", 32'(abort), 32'd1);
    chk("to_busy",  32'(busy),  32'd0);
    chk("to_sel",   32'(sel),   32'd0);
    chk_frame("to_hold", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5);
    cyc();
    chk("to_abort_one_cycle", 32'(abort), 32'd0);
`else
    for (int i = 0; i < int'(TO) + 8; i++) begin
      cyc();
      if (abort !== 1'b0) chk("to_no_abort", 32'(abort), 32'd0);
    end
    chk("to_busy", 32'(busy), 32'd1);
    chk("to_sel",  32'(sel),  32'd2);
    send_byte("to_b2", 8'hB2, 2);
    send_byte("to_b3", 8'hB3, 3);
    send_byte("to_b4", 8'hB4, 4);
    send_byte("to_b5", 8'hB5, 5);
    chk_frame("to_late", 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5);
    cyc();
`endif

    // Back-to-back frames
    pulse_start();
    send_byte("bb1_b0", 8'hC0, 0);
    send_byte("bb1_b1", 8'hC1, 1);
    send_byte("bb1_b2", 8'hC2, 2);
    send_byte("bb1_b3", 8'hC3, 3);
    send_byte("bb1_b4", 8'hC4, 4);
    send_byte("bb1_b5", 8'hC5, 5);
    chk_frame("bb1", 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5);
    pulse_start();
    chk("bb_start_fv",    32'(frame_valid), 32'd0);
    chk("bb_start_abort", 32'(abort),       32'd0);
    chk("bb_start_busy",  32'(busy),        32'd1);
    send_byte("bb2_b0", 8'hD0, 0);
    send_byte("bb2_b1", 8'hD1, 1);
    send_byte("bb2_b2", 8'hD2, 2);
    send_byte("bb2_b3", 8'hD3, 3);
    send_byte("bb2_b4", 8'hD4, 4);
    send_byte("bb2_b5", 8'hD5, 5);
    chk_frame("bb2", 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5);
    cyc();

    // Reset in the middle of a frame
    pulse_start();
    send_byte("mr_b0", 8'hE0, 0);
    send_byte("mr_b1", 8'hE1, 1);
    send_byte("mr_b2", 8'hE2, 2);
    send_byte("mr_b3", 8'hE3, 3);
    rst = 1'b1;
    #1;
    chk("mr_sel",  32'(sel),  32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk_frame("mr", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    cyc();
    rst = 1'b0;
    cyc();
    chk("mr_fv",    32'(frame_valid), 32'd0);
    chk("mr_abort", 32'(abort),       32'd0);
    chk("mr_stray", 32'(stray),       32'd0);
    chk("mr_busy2", 32'(busy),        32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acl2_burst_demux.md
# acl2_burst_demux

Receive-side counterpart of the six-channel sample selector in the PmodACL2 wrapper: takes the byte stream produced by an ADXL362 burst read (XDATA_L, XDATA_H, YDATA_L, YDATA_H, ZDATA_L, ZDATA_H) and steers each byte into one of six output registers. Outputs update atomically once all six bytes of a frame have arrived, so downstream logic and the selector never see a mixed frame. Sits between the SPI master byte interface and the sample consumers.

## Interface
- WIDTH, 8, width of each byte/channel
- TIMEOUT_CYCLES, 1024, maximum idle cycles between bytes inside a frame (used only when the timeout is compiled in)

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; SPI master has begun a burst read
- din  input  WIDTH  received byte
- din_valid  input  1  din valid this cycle
- d0..d5  output  WIDTH each  committed frame, byte k of the burst on dk
- sel  output  3  index of the next byte to be captured (0..5)
- busy  output  1  high while a frame is being collected
- frame_valid  output  1  one-cycle pulse; d0..d5 just updated
- abort  output  1  one-cycle pulse; partial frame discarded
- stray  output  1  one-cycle pulse; din_valid received outside a frame

## Operation
- States: IDLE, COLLECT.
- IDLE: start -> COLLECT, sel=0. din_valid without start -> stray pulse, byte dropped.
- COLLECT: each din_valid writes din into staging[sel] and increments sel. On din_valid with sel==5: d0..d5 loaded from staging[0..4] plus din, frame_valid pulses, sel=0, -> IDLE.
- start while in COLLECT: abort pulse, staging discarded, sel=0, stay COLLECT.
- start and din_valid in the same cycle (either state): start wins, byte dropped, stray pulses. In COLLECT, abort also pulses.
- d0..d5 change only on frame completion; aborted frames never reach them.
- sel never exceeds 5; there is no wrap other than the explicit return to 0.
- busy = (state == COLLECT).

## Timing
- Reset: state IDLE, sel=0, busy=0, d0..d5=0, frame_valid=0, abort=0, stray=0, staging=0.
- All outputs registered.
- frame_valid and new d0..d5 appear on the edge following the clock edge at which the 6th din_valid is sampled (1-cycle latency).
- abort/stray assert one cycle after the causing input and last exactly one cycle.
- Back-to-back frames: start may be asserted the cycle after the 6th byte; no dead cycle required.
- Reset mid-frame: all state cleared immediately; no frame_valid or abort issued.

## Configuration
- ACL2_DEMUX_TIMEOUT_EN defined: in COLLECT, a counter counts cycles since start or the last accepted byte; on reaching TIMEOUT_CYCLES -> abort pulse, sel=0, IDLE, d0..d5 unchanged. Counter cleared on every accepted byte or start; width $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter; a stalled partial frame stays in COLLECT indefinitely until start or rst.

## Structure
- Shared package acl2_pkg: state enum (IDLE, COLLECT), NUM_CH=6 localparam, LAST_IDX=5, 3-bit index typedef.
- One sub-module: acl2_watchdog (loadable down-counter with expiry pulse), instantiated only under ACL2_DEMUX_TIMEOUT_EN.

## Test plan
- Reset, start, bytes 0x11,0x22,0x33,0x44,0x55,0x66 on consecutive cycles -> frame_valid one cycle after 0x66; d0=0x11 ... d5=0x66; busy low afterwards.
- Start, 3 bytes, start again, 6 bytes 0xA0..0xA5 -> one abort pulse; d0..d5 = 0xA0..0xA5; no frame_valid for the partial frame.
- din_valid=1 with din=0x7F in IDLE -> stray pulse; d0..d5 and sel unchanged.
- Start, 2 bytes, then stall TIMEOUT_CYCLES with ACL2_DEMUX_TIMEOUT_EN -> abort after exactly TIMEOUT_CYCLES cycles, state IDLE; without the macro -> busy stays high, sel=2.
- Two frames back-to-back with start the cycle after the 6th byte -> two frame_valid pulses, second frame's data on d0..d5.
- Assert rst after byte 4 -> sel=0, busy=0, d0..d5 keep reset/previous-clear value 0, no pulses.
